// File: rtl/intra_residue_gen.sv
// Intra prediction residue generator: latches a block and its neighbours, forms the
// vertical/horizontal/DC prediction and writes one saturated residue row per cycle.
module intra_residue_gen #(
  parameter int MB_SIZE_L = 4,
  parameter int MB_SIZE_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [2:0]        mode,
  input  logic              top_avail,
  input  logic              left_avail,
  input  logic [7:0]        toppixels  [8],
  input  logic [7:0]        leftpixels [MB_SIZE_L],
  input  logic [7:0]        original   [MB_SIZE_L*MB_SIZE_W],
  output logic signed [7:0] residue    [MB_SIZE_L*MB_SIZE_W],
  output logic              busy,
  output logic              fb
);

  localparam int NPIX  = MB_SIZE_L * MB_SIZE_W;
  localparam int RW    = (MB_SIZE_L > 1) ? $clog2(MB_SIZE_L) : 1;
  localparam int LOG2N = $clog2(MB_SIZE_W);
  localparam logic [RW-1:0] ROW_LAST = RW'(MB_SIZE_L - 1);

  localparam logic [1:0] PM_V  = 2'd0;
  localparam logic [1:0] PM_H  = 2'd1;
  localparam logic [1:0] PM_DC = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_PREP, S_ROW, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [RW-1:0]   row_q, row_d;
  logic [2:0]      mode_q;
  logic            top_av_q, left_av_q;
  logic [7:0]      tpx_q [MB_SIZE_W];
  logic [7:0]      lpx_q [MB_SIZE_L];
  logic [7:0]      org_q [NPIX];
  logic [1:0]      pmode_q, pmode_d;
  logic [7:0]      dc_q, dc_d;
  logic [11:0]     sum_top, sum_left;
  logic [12:0]     acc_both;
  logic [11:0]     acc_top, acc_left;
  logic [7:0]      pred_px [NPIX];
  logic signed [7:0] res_q [NPIX];
  logic            unused_top;

  function automatic logic signed [8:0] diff9(input logic [7:0] a, input logic [7:0] b);
    return $signed({1'b0, a}) - $signed({1'b0, b});
  endfunction

  function automatic logic signed [7:0] sat8(input logic signed [8:0] d);
    if (d > 9'sd127)
      return 8'sd127;
    else if (d < -9'sd128)
      return $signed(8'h80);
    else
      return d[7:0];
  endfunction

  // Top neighbours beyond the block width are never used by narrower instances
  always_comb begin
    unused_top = 1'b0;
    for (int i = MB_SIZE_W; i < 8; i++) unused_top = unused_top ^ (^toppixels[i]);
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    case (state_q)
      S_IDLE: if (enable) state_d = S_PREP;
      S_PREP: begin
        row_d   = '0;
        state_d = S_ROW;
      end
      S_ROW: begin
        row_d = row_q + 1'b1;
        if (row_q == ROW_LAST) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy = (state_q != S_IDLE);
    fb   = (state_q == S_DONE);
  end

  // Input capture stage: block and neighbours are frozen at the start strobe
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && enable) begin
      mode_q    <= mode;
      top_av_q  <= top_avail;
      left_av_q <= left_avail;
      for (int c = 0; c < MB_SIZE_W; c++) tpx_q[c] <= toppixels[c];
      for (int r = 0; r < MB_SIZE_L; r++) lpx_q[r] <= leftpixels[r];
      for (int i = 0; i < NPIX; i++)      org_q[i] <= original[i];
    end
  end

  always_comb begin
    sum_top  = '0;
    sum_left = '0;
    for (int c = 0; c < MB_SIZE_W; c++) sum_top  = sum_top  + 12'(tpx_q[c]);
    for (int r = 0; r < MB_SIZE_L; r++) sum_left = sum_left + 12'(lpx_q[r]);
    acc_both = 13'(sum_top) + 13'(sum_left) + 13'(MB_SIZE_W);
    acc_top  = sum_top  + 12'(MB_SIZE_W / 2);
    acc_left = sum_left + 12'(MB_SIZE_W / 2);
    case ({top_av_q, left_av_q})
      2'b11:   dc_d = 8'(acc_both >> (LOG2N + 1));
      2'b10:   dc_d = 8'(acc_top >> LOG2N);
      2'b01:   dc_d = 8'(acc_left >> LOG2N);
      default: dc_d = 8'd128;
    endcase
    // Directional modes without their neighbours degrade to DC
    if (mode_q == 3'd0 && top_av_q)
      pmode_d = PM_V;
    else if (mode_q == 3'd1 && left_av_q)
      pmode_d = PM_H;
    else
      pmode_d = PM_DC;
  end

  // Prep stage: resolve prediction mode and DC value once per block
  always_ff @(posedge clk) begin
    if (state_q == S_PREP) begin
      dc_q    <= dc_d;
      pmode_q <= pmode_d;
    end
  end

  always_comb begin
    for (int r = 0; r < MB_SIZE_L; r++) begin
      for (int c = 0; c < MB_SIZE_W; c++) begin
        case (pmode_q)
          PM_V:    pred_px[r*MB_SIZE_W + c] = tpx_q[c];
          PM_H:    pred_px[r*MB_SIZE_W + c] = lpx_q[r];
          default: pred_px[r*MB_SIZE_W + c] = dc_q;
        endcase
      end
    end
  end

  // Row stage: one residue row per cycle, other rows hold
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NPIX; i++) res_q[i] <= '0;
    end else if (state_q == S_ROW) begin
      for (int r = 0; r < MB_SIZE_L; r++) begin
        if (row_q == RW'(r)) begin
          for (int c = 0; c < MB_SIZE_W; c++)
            res_q[r*MB_SIZE_W + c] <= sat8(diff9(org_q[r*MB_SIZE_W + c], pred_px[r*MB_SIZE_W + c]));
        end
      end
    end
  end

  assign residue = res_q;

endmodule
